// File: rtl/pulse_train_ctrl_pkg.sv
// rtl/pulse_train_ctrl_pkg.sv - shared state encoding and defaults for the pulse-train controller
package pulse_train_ctrl_pkg;

    // 3-bit encoding leaves spare codes; any of them decodes back to ST_IDLE.
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RUN_H = 3'd1,
        ST_RUN_L = 3'd2,
        ST_DONE  = 3'd3
    } state_e;

    // Settings of the fixed-function predecessor (8 high, 1 low, 10 pulses).
    localparam int LEGACY_HIGH   = 8;
    localparam int LEGACY_LOW    = 1;
    localparam int LEGACY_PULSES = 10;

    localparam int DEF_CNT_W   = 8;
    localparam int DEF_PULSE_W = 8;
    localparam int DEF_NUM_CH  = 4;

    function automatic logic is_running(input state_e s);
        return (s == ST_RUN_H) || (s == ST_RUN_L);
    endfunction

endpackage

// File: rtl/pulse_train_ctrl_if.sv
// rtl/pulse_train_ctrl_if.sv - sequencer-side bus of the pulse-train controller
//
// master : test sequencer (drives start/abort/config, observes status and outputs)
// slave  : pulse_train_ctrl
//   start, abort         control levels
//   cfg_high, cfg_low    phase lengths in cycles (0 treated as 1)
//   cfg_pulses           pulses per train (0 = empty train)
//   cfg_ch_en, cfg_cont  channel mask, continuous mode
//   out, running, bist_end, pulse_idx   status and channel outputs
interface pulse_train_ctrl_if
    import pulse_train_ctrl_pkg::*;
#(
    parameter int CNT_W   = DEF_CNT_W,
    parameter int PULSE_W = DEF_PULSE_W,
    parameter int NUM_CH  = DEF_NUM_CH
) ();

    logic               start;
    logic               abort;
    logic [CNT_W-1:0]   cfg_high;
    logic [CNT_W-1:0]   cfg_low;
    logic [PULSE_W-1:0] cfg_pulses;
    logic [NUM_CH-1:0]  cfg_ch_en;
    logic               cfg_cont;
    logic [NUM_CH-1:0]  out;
    logic               running;
    logic               bist_end;
    logic [PULSE_W-1:0] pulse_idx;

    modport master (
        output start, abort, cfg_high, cfg_low, cfg_pulses, cfg_ch_en, cfg_cont,
        input  out, running, bist_end, pulse_idx
    );

    modport slave (
        input  start, abort, cfg_high, cfg_low, cfg_pulses, cfg_ch_en, cfg_cont,
        output out, running, bist_end, pulse_idx
    );

endinterface

// File: rtl/pulse_train_ctrl_counter_nb.sv
// rtl/pulse_train_ctrl_counter_nb.sv - parametrised up-counter with synchronous reset, clear and enable
//
// clk, reset : clock, synchronous active-high reset
// clr        : clear to zero (wins over en)
// en         : increment by one
// count      : current value
module counter_nb #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] count
);

    localparam logic [W-1:0] ONE = W'(1);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (en) begin
            count_d = count_q + ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/pulse_train_ctrl.sv
// rtl/pulse_train_ctrl.sv - programmable BIST pulse-train controller
//
// clk   : clock
// reset : synchronous, active-high reset
// bus   : pulse_train_ctrl_if.slave (start/abort/config in; out/running/bist_end/pulse_idx out)
module pulse_train_ctrl
    import pulse_train_ctrl_pkg::*;
#(
    parameter int CNT_W   = DEF_CNT_W,
    parameter int PULSE_W = DEF_PULSE_W,
    parameter int NUM_CH  = DEF_NUM_CH
) (
    input  logic              clk,
    input  logic              reset,
    pulse_train_ctrl_if.slave bus
);

    localparam logic [CNT_W-1:0]   ONE_C = CNT_W'(1);
    localparam logic [PULSE_W-1:0] ONE_P = PULSE_W'(1);

    state_e             state_q, state_d;
    logic               start_q;
    logic               pos_start_q, pos_start_d;
    logic [CNT_W-1:0]   high_l_q, high_l_d;
    logic [CNT_W-1:0]   low_l_q, low_l_d;
    logic [PULSE_W-1:0] pulses_l_q, pulses_l_d;
    logic [NUM_CH-1:0]  ch_en_l_q, ch_en_l_d;
    logic               cont_l_q, cont_l_d;
    logic [NUM_CH-1:0]  out_q, out_d;
    logic               running_q, running_d;
    logic               bist_end_q, bist_end_d;

    logic               ph_clr, ph_en;
    logic               pc_clr, pc_en;
    logic [CNT_W-1:0]   phase;
    logic [PULSE_W-1:0] pulse_idx;

    // Last phase value of each half-period; a zero length behaves like one.
    logic [CNT_W-1:0]   high_last, low_last;
    logic [PULSE_W-1:0] pulse_last;

    assign high_last  = (high_l_q == '0) ? '0 : high_l_q - ONE_C;
    assign low_last   = (low_l_q  == '0) ? '0 : low_l_q  - ONE_C;
    assign pulse_last = pulses_l_q - ONE_P;

    counter_nb #(.W(CNT_W)) u_phase_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (ph_clr),
        .en    (ph_en),
        .count (phase)
    );

    counter_nb #(.W(PULSE_W)) u_pulse_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (pc_clr),
        .en    (pc_en),
        .count (pulse_idx)
    );

    always_comb begin
        state_d     = state_q;
        pos_start_d = bus.start & ~start_q;
        high_l_d    = high_l_q;
        low_l_d     = low_l_q;
        pulses_l_d  = pulses_l_q;
        ch_en_l_d   = ch_en_l_q;
        cont_l_d    = cont_l_q;
        ph_clr      = 1'b0;
        ph_en       = 1'b0;
        pc_clr      = 1'b0;
        pc_en       = 1'b0;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                // abort in these states only swallows the launch.
                if (pos_start_q && !bus.abort) begin
                    high_l_d   = bus.cfg_high;
                    low_l_d    = bus.cfg_low;
                    pulses_l_d = bus.cfg_pulses;
                    ch_en_l_d  = bus.cfg_ch_en;
                    cont_l_d   = bus.cfg_cont;
                    ph_clr     = 1'b1;
                    pc_clr     = 1'b1;
                    state_d    = (bus.cfg_pulses == '0) ? ST_DONE : ST_RUN_H;
                end
            end
            ST_RUN_H: begin
                if (bus.abort) begin
                    ph_clr  = 1'b1;
                    pc_clr  = 1'b1;
                    state_d = ST_IDLE;
                end else if (phase == high_last) begin
                    ph_clr  = 1'b1;
                    state_d = (pulse_idx == pulse_last && !cont_l_q) ? ST_DONE : ST_RUN_L;
                end else begin
                    ph_en = 1'b1;
                end
            end
            ST_RUN_L: begin
                if (bus.abort) begin
                    ph_clr  = 1'b1;
                    pc_clr  = 1'b1;
                    state_d = ST_IDLE;
                end else if (phase == low_last) begin
                    ph_clr  = 1'b1;
                    state_d = ST_RUN_H;
                    // Only continuous mode reaches the end of a low phase on the last pulse.
                    if (pulse_idx == pulse_last) begin
                        pc_clr = 1'b1;
                    end else begin
                        pc_en = 1'b1;
                    end
                end else begin
                    ph_en = 1'b1;
                end
            end
            default: begin
                ph_clr  = 1'b1;
                pc_clr  = 1'b1;
                state_d = ST_IDLE;
            end
        endcase

        // Outputs are registered from the next state so they line up with state_q.
        out_d      = (state_d == ST_RUN_H) ? ch_en_l_d : '0;
        running_d  = is_running(state_d);
        bist_end_d = (state_d == ST_DONE);
    end

    always_ff @(posedge clk) begin
        // Sampled through reset too, so a start held high across reset release is not an edge.
        start_q <= bus.start;
        if (reset) begin
            state_q     <= ST_IDLE;
            pos_start_q <= 1'b0;
            high_l_q    <= '0;
            low_l_q     <= '0;
            pulses_l_q  <= '0;
            ch_en_l_q   <= '0;
            cont_l_q    <= 1'b0;
            out_q       <= '0;
            running_q   <= 1'b0;
            bist_end_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            pos_start_q <= pos_start_d;
            high_l_q    <= high_l_d;
            low_l_q     <= low_l_d;
            pulses_l_q  <= pulses_l_d;
            ch_en_l_q   <= ch_en_l_d;
            cont_l_q    <= cont_l_d;
            out_q       <= out_d;
            running_q   <= running_d;
            bist_end_q  <= bist_end_d;
        end
    end

    assign bus.out       = out_q;
    assign bus.running   = running_q;
    assign bus.bist_end  = bist_end_q;
    assign bus.pulse_idx = pulse_idx;

endmodule

// File: tb/tb_pulse_train_ctrl.sv
// tb/tb_pulse_train_ctrl.sv - directed self-checking bench for pulse_train_ctrl
module tb_pulse_train_ctrl;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    pulse_train_ctrl_if #(.CNT_W(8), .PULSE_W(8), .NUM_CH(4)) bus ();

    pulse_train_ctrl #(.CNT_W(8), .PULSE_W(8), .NUM_CH(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_cfg(input int h, input int l, input int p, input logic [3:0] ch, input logic cont);
        bus.cfg_high   = 8'(h);
        bus.cfg_low    = 8'(l);
        bus.cfg_pulses = 8'(p);
        bus.cfg_ch_en  = ch;
        bus.cfg_cont   = cont;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.start = 1'b0;
        bus.abort = 1'b0;
        set_cfg(0, 0, 0, 4'h0, 1'b0);
        repeat (3) tick();
        checks++;
        if (bus.out !== 4'h0 || bus.running !== 1'b0 || bus.bist_end !== 1'b0 || bus.pulse_idx !== 8'd0) begin
            errors++;
            $display("FAIL reset_state out=%b running=%b bist_end=%b idx=%0d required 0000/0/0/0",
                     bus.out, bus.running, bus.bist_end, bus.pulse_idx);
        end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_legacy();
        logic [3:0] exp;
        set_cfg(8, 1, 10, 4'hf, 1'b0);
        bus.start = 1'b0; tick();
        bus.start = 1'b1; tick();
        checks++;
        if (bus.out !== 4'h0 || bus.running !== 1'b0) begin
            errors++;
            $display("FAIL legacy_edge_k out=%b running=%b required 0000/0", bus.out, bus.running);
        end
        for (int c = 0; c < 89; c++) begin
            tick();
            exp = ((c % 9) < 8) ? 4'hf : 4'h0;
            checks++;
            if (bus.out !== exp || bus.running !== 1'b1 || bus.bist_end !== 1'b0) begin
                errors++;
                $display("FAIL legacy_cycle c=%0d out=%b running=%b bist_end=%b required %b/1/0",
                         c, bus.out, bus.running, bus.bist_end, exp);
            end
        end
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++;
            if (bus.bist_end !== 1'b1 || bus.running !== 1'b0 || bus.out !== 4'h0 || bus.pulse_idx !== 8'd9) begin
                errors++;
                $display("FAIL legacy_done k=%0d bist_end=%b running=%b out=%b idx=%0d required 1/0/0000/9",
                         k, bus.bist_end, bus.running, bus.out, bus.pulse_idx);
            end
        end
    endtask

    task automatic test_mask();
        logic [3:0] exp;
        set_cfg(3, 2, 2, 4'b0101, 1'b0);
        bus.start = 1'b0; tick();
        bus.start = 1'b1; tick();
        for (int c = 0; c < 8; c++) begin
            tick();
            exp = ((c % 5) < 3) ? 4'b0101 : 4'b0000;
            checks++;
            if (bus.out !== exp || bus.running !== 1'b1 || bus.bist_end !== 1'b0) begin
                errors++;
                $display("FAIL mask_cycle c=%0d out=%b running=%b bist_end=%b required %b/1/0",
                         c, bus.out, bus.running, bus.bist_end, exp);
            end
        end
        tick();
        checks++;
        if (bus.bist_end !== 1'b1 || bus.out !== 4'h0 || bus.pulse_idx !== 8'd1) begin
            errors++;
            $display("FAIL mask_done bist_end=%b out=%b idx=%0d required 1/0000/1", bus.bist_end, bus.out, bus.pulse_idx);
        end
    endtask

    task automatic test_zero_values();
        logic [3:0] exp;
        set_cfg(0, 0, 3, 4'b1010, 1'b0);
        bus.start = 1'b0; tick();
        bus.start = 1'b1; tick();
        for (int c = 0; c < 5; c++) begin
            tick();
            exp = ((c % 2) == 0) ? 4'b1010 : 4'b0000;
            checks++;
            if (bus.out !== exp || bus.running !== 1'b1) begin
                errors++;
                $display("FAIL zero_hl_cycle c=%0d out=%b running=%b required %b/1", c, bus.out, bus.running, exp);
            end
        end
        tick();
        checks++;
        if (bus.bist_end !== 1'b1 || bus.pulse_idx !== 8'd2) begin
            errors++;
            $display("FAIL zero_hl_done bist_end=%b idx=%0d required 1/2", bus.bist_end, bus.pulse_idx);
        end
        // Empty train launched from DONE.
        set_cfg(4, 4, 0, 4'hf, 1'b0);
        bus.start = 1'b0; tick();
        bus.start = 1'b1; tick();
        checks++;
        if (bus.bist_end !== 1'b1 || bus.pulse_idx !== 8'd2) begin
            errors++;
            $display("FAIL zero_p_edge_k bist_end=%b idx=%0d required 1/2", bus.bist_end, bus.pulse_idx);
        end
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++;
            if (bus.bist_end !== 1'b1 || bus.running !== 1'b0 || bus.out !== 4'h0 || bus.pulse_idx !== 8'd0) begin
                errors++;
                $display("FAIL zero_p_done k=%0d bist_end=%b running=%b out=%b idx=%0d required 1/0/0000/0",
                         k, bus.bist_end, bus.running, bus.out, bus.pulse_idx);
            end
        end
    endtask

    task automatic test_continuous_abort();
        logic [3:0] exp;
        logic [7:0] exp_idx;
        set_cfg(2, 2, 3, 4'b0011, 1'b1);
        bus.start = 1'b0; tick();
        bus.start = 1'b1; tick();
        for (int c = 0; c < 24; c++) begin
            tick();
            exp     = ((c % 4) < 2) ? 4'b0011 : 4'b0000;
            exp_idx = 8'((c / 4) % 3);
            checks++;
            if (bus.out !== exp || bus.pulse_idx !== exp_idx || bus.bist_end !== 1'b0 || bus.running !== 1'b1) begin
                errors++;
                $display("FAIL cont_cycle c=%0d out=%b idx=%0d bist_end=%b running=%b required %b/%0d/0/1",
                         c, bus.out, bus.pulse_idx, bus.bist_end, bus.running, exp, exp_idx);
            end
        end
        tick();
        checks++;
        if (bus.out !== 4'b0011) begin
            errors++;
            $display("FAIL cont_run_h out=%b required 0011", bus.out);
        end
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        checks++;
        if (bus.out !== 4'h0 || bus.running !== 1'b0 || bus.bist_end !== 1'b0) begin
            errors++;
            $display("FAIL abort_run_h out=%b running=%b bist_end=%b required 0000/0/0", bus.out, bus.running, bus.bist_end);
        end
        // abort in IDLE swallows the launch.
        bus.cfg_cont = 1'b0;
        bus.start = 1'b0; tick();
        bus.start = 1'b1; tick();
        bus.abort = 1'b1; tick();
        bus.abort = 1'b0;
        checks++;
        if (bus.running !== 1'b0) begin
            errors++;
            $display("FAIL abort_blocks_launch running=%b required 0", bus.running);
        end
        tick();
        checks++;
        if (bus.running !== 1'b0 || bus.bist_end !== 1'b0) begin
            errors++;
            $display("FAIL abort_blocks_launch_hold running=%b bist_end=%b required 0/0", bus.running, bus.bist_end);
        end
    endtask

    task automatic test_retrigger_relaunch();
        logic [3:0] exp;
        set_cfg(4, 1, 3, 4'hf, 1'b0);
        bus.start = 1'b0; tick();
        bus.start = 1'b1; tick();
        for (int c = 0; c < 14; c++) begin
            tick();
            exp = ((c % 5) < 4) ? 4'hf : 4'h0;
            checks++;
            if (bus.out !== exp || bus.running !== 1'b1) begin
                errors++;
                $display("FAIL retrig_cycle c=%0d out=%b running=%b required %b/1", c, bus.out, bus.running, exp);
            end
            if (c == 2) bus.start = 1'b0;
            if (c == 5) begin
                bus.start    = 1'b1;
                bus.cfg_high = 8'd7;
            end
        end
        tick();
        checks++;
        if (bus.bist_end !== 1'b1 || bus.pulse_idx !== 8'd2) begin
            errors++;
            $display("FAIL retrig_done bist_end=%b idx=%0d required 1/2", bus.bist_end, bus.pulse_idx);
        end
        bus.start = 1'b0; tick();
        bus.start = 1'b1; tick();
        checks++;
        if (bus.bist_end !== 1'b1) begin
            errors++;
            $display("FAIL relaunch_edge_k bist_end=%b required 1", bus.bist_end);
        end
        tick();
        checks++;
        if (bus.bist_end !== 1'b0 || bus.running !== 1'b1 || bus.out !== 4'hf) begin
            errors++;
            $display("FAIL relaunch_start bist_end=%b running=%b out=%b required 0/1/1111",
                     bus.bist_end, bus.running, bus.out);
        end
        // Relaunched with H=7: cycles 0..6 high, cycle 7 is the first RUN_L cycle.
        repeat (7) tick();
        checks++;
        if (bus.out !== 4'h0 || bus.running !== 1'b1 || bus.pulse_idx !== 8'd0) begin
            errors++;
            $display("FAIL relaunch_run_l out=%b running=%b idx=%0d required 0000/1/0", bus.out, bus.running, bus.pulse_idx);
        end
    endtask

    task automatic test_reset_mid_run();
        reset = 1'b1;
        tick();
        checks++;
        if (bus.out !== 4'h0 || bus.running !== 1'b0 || bus.bist_end !== 1'b0 || bus.pulse_idx !== 8'd0) begin
            errors++;
            $display("FAIL reset_mid_run out=%b running=%b bist_end=%b idx=%0d required 0000/0/0/0",
                     bus.out, bus.running, bus.bist_end, bus.pulse_idx);
        end
        reset = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++;
            if (bus.running !== 1'b0 || bus.out !== 4'h0) begin
                errors++;
                $display("FAIL held_start_no_launch k=%0d running=%b out=%b required 0/0000", k, bus.running, bus.out);
            end
        end
        bus.start = 1'b0; tick();
        bus.start = 1'b1; tick();
        tick();
        checks++;
        if (bus.running !== 1'b1 || bus.out !== 4'hf) begin
            errors++;
            $display("FAIL toggle_after_reset running=%b out=%b required 1/1111", bus.running, bus.out);
        end
    endtask

    initial begin
        test_reset();
        test_legacy();
        test_mask();
        test_zero_values();
        test_continuous_abort();
        test_retrigger_relaunch();
        test_reset_mid_run();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pulse_train_ctrl.md
Name: pulse_train_ctrl

Overview:
- Parametrised BIST pulse-train controller; next generation of the fixed 8-high/1-low/10-pulse controller.
- A rising edge on start launches a train of cfg_pulses pulses on up to NUM_CH channel outputs.
- High width, low width and pulse count are runtime-programmable. The block also supports continuous mode and abort.
- Sits between the test sequencer and the BIST stimulus channels; bist_end and running are reported back to the sequencer.

Parameters:
- CNT_W, 8, width of the phase (high/low length) counter and of cfg_high/cfg_low.
- PULSE_W, 8, width of the pulse counter and of cfg_pulses/pulse_idx.
- NUM_CH, 4, number of pulse output channels.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  level input; only its rising edge launches a train.
- abort  in  1  level; terminates a running train.
- cfg_high  in  CNT_W  high-phase length in cycles; 0 is treated as 1.
- cfg_low  in  CNT_W  low-phase length in cycles; 0 is treated as 1.
- cfg_pulses  in  PULSE_W  number of pulses per train; 0 means an empty train.
- cfg_ch_en  in  NUM_CH  per-channel output enable mask.
- cfg_cont  in  1  continuous mode: the train repeats until abort.
- out  out  NUM_CH  pulse outputs.
- running  out  1  high in RUN_H and RUN_L.
- bist_end  out  1  train completed normally.
- pulse_idx  out  PULSE_W  index of the current pulse, 0-based.

Behaviour:
- Reset state: IDLE. out=0, running=0, bist_end=0, pulse_idx=0, all counters 0. reset has priority over every other input.
- Edge detect: start_q is registered every cycle. pos_start is a register loaded with start & ~start_q.
  - If start is first sampled high at edge k, pos_start is high after edge k.
  - The FSM enters RUN_H at edge k+1.
- Launch (IDLE or DONE with pos_start=1):
  - cfg_high, cfg_low, cfg_pulses, cfg_ch_en and cfg_cont are latched.
  - Config changes during a run have no effect.
  - Phase and pulse counters are cleared and bist_end drops.
  - If the latched cfg_pulses is 0, the FSM goes directly to DONE with no output pulse.
- Outputs are Moore, decoded from registered state and latched config only:
  - out = ch_en_l in RUN_H, else 0.
  - bist_end=1 only in DONE.
- RUN_H:
  - The phase counter counts 0..H-1.
  - At phase H-1, if pulse_idx = P-1 and cont_l=0, go to DONE; otherwise go to RUN_L. The phase counter clears.
- RUN_L:
  - out=0; the phase counter counts 0..L-1.
  - At L-1, go to RUN_H and increment pulse_idx.
  - In continuous mode pulse_idx wraps from P-1 to 0.
- Train timing: H high cycles, L low cycles, P pulses. Run length is P*H+(P-1)*L cycles. bist_end is high in the cycle after the last high cycle.
- DONE: holds bist_end=1 until a new launch or reset. pulse_idx holds P-1.
- abort:
  - In RUN_H or RUN_L, abort=1 sends the FSM to IDLE at the next edge: out=0, running=0, bist_end=0.
  - abort has priority over end-of-train and over pos_start.
  - In IDLE or DONE, abort=1 blocks a launch in that cycle; the state is unchanged.
- pos_start during RUN_H or RUN_L is ignored; no retrigger.
- Holding start high does not relaunch; a new 0→1 transition is required.
- Counters never wrap during normal runs, because the compare happens at the latched limit.
- Illegal state encodings return to IDLE with all outputs 0.

Decomposition:
- Shared params package holds:
  - state encoding IDLE=0, RUN_H=1, RUN_L=2, DONE=3 (3-bit);
  - legacy defaults LEGACY_HIGH=8, LEGACY_LOW=1, LEGACY_PULSES=10.
- One sub-module, counter_nb: parametrised-width up-counter with synchronous reset and enable; the generalised 4-bit counter. It is instantiated twice: phase counter (CNT_W) and pulse counter (PULSE_W).

Test Plan:
- Legacy config (H=8, L=1, P=10, ch_en=4'b1111, cont=0), start 0→1:
  - out rises 2 edges after start is sampled high;
  - 10 pulses of 8 cycles separated by 1 low cycle, running high for 89 cycles;
  - then bist_end=1 held, pulse_idx=9.
- H=3, L=2, P=2, ch_en=4'b0101:
  - only out[0] and out[2] pulse, pattern 111 00 111;
  - out[1] and out[3] stay 0;
  - bist_end rises after 8 running cycles.
- Zero-value handling:
  - H=0, L=0, P=3 gives 3 one-cycle pulses separated by 1 low cycle;
  - P=0 gives DONE two edges after start, with no out activity.
- Continuous mode (H=2, L=2, P=3, cont=1):
  - pulse_idx cycles 0,1,2,0,… for over 20 cycles with no bist_end;
  - abort during RUN_H gives out=0, running=0, bist_end=0 after one edge.
- Retrigger and config changes:
  - a second start edge mid-train is ignored; cfg_high changed mid-train does not alter pulse width;
  - start edge in DONE relaunches, bist_end drops at launch.
- reset asserted mid-RUN_L: next cycle IDLE with all outputs 0; start held high through reset release does not launch until it toggles 0→1.
